// File: rtl/sdf_cross_pipe.sv
// sdf_cross_pipe: pipelined FP27 signed distance to an axis-aligned cross, with an optional cube bound.
// Results queue in a credit-protected FWFT FIFO, so the datapath itself never stalls.
module sdf_fp_add (
    input  logic        clk,
    input  logic [26:0] a,
    input  logic [26:0] b,
    output logic [26:0] y
);
    logic        a_big, sub, s_sgn, inc;
    logic [26:0] hi, lo, y_n;
    logic [21:0] sig_hi, sig_lo, al, norm;
    logic [7:0]  d, s_e;
    logic [4:0]  sh, lz;
    logic [43:0] wide;
    logic [22:0] sum, s_sum;
    logic [9:0]  en, er;
    logic [19:0] mr;
    logic [17:0] frac;

    function automatic logic [4:0] lzc(input logic [21:0] v);
        lzc = 5'd22;
        for (int i = 0; i < 22; i++)
            if (v[i]) lzc = 5'(21 - i);
    endfunction

    // Stage A: order by magnitude, align the smaller operand keeping guard/round/sticky, add.
    always_comb begin
        a_big  = a[25:0] >= b[25:0];
        hi     = a_big ? a : b;
        lo     = a_big ? b : a;
        sub    = hi[26] ^ lo[26];
        sig_hi = hi[25:18] == 8'd0 ? 22'd0 : {1'b1, hi[17:0], 3'b000};
        sig_lo = lo[25:18] == 8'd0 ? 22'd0 : {1'b1, lo[17:0], 3'b000};
        d      = hi[25:18] - lo[25:18];
        sh     = d > 8'd25 ? 5'd25 : d[4:0];
        wide   = {sig_lo, 22'd0} >> sh;
        al     = {wide[43:23], wide[22] | (|wide[21:0])};
        sum    = sub ? {1'b0, sig_hi} - {1'b0, al} : {1'b0, sig_hi} + {1'b0, al};
    end

    // Stage B: normalise, round to nearest even, flush underflow to +0.
    always_comb begin
        lz   = lzc(s_sum[21:0]);
        norm = s_sum[22] ? {s_sum[22:2], s_sum[1] | s_sum[0]} : s_sum[21:0] << lz;
        en   = s_sum[22] ? {2'b00, s_e} + 10'd1 : {2'b00, s_e} - {5'd0, lz};
        inc  = norm[2] & (norm[3] | norm[1] | norm[0]);
        mr   = {1'b0, norm[21:3]} + {19'd0, inc};
        er   = en + {9'd0, mr[19]};
        frac = mr[19] ? mr[18:1] : mr[17:0];
        y_n  = (s_sum == 23'd0 || $signed(en) <= 10'sd0) ? 27'd0 :
               $signed(er) >= 10'sd255 ? {s_sgn, 8'hff, 18'd0} : {s_sgn, er[7:0], frac};
    end

    always_ff @(posedge clk) begin
        s_sum <= sum;
        s_e   <= hi[25:18];
        s_sgn <= hi[26];
        y     <= y_n;
    end
endmodule

module sdf_cross_pipe #(
    parameter logic [26:0] ARM        = 27'h1fc0000,
    parameter bit          BOUND_EN   = 1'b0,
    parameter logic [26:0] BOUND      = 27'h2040000,
    parameter int          TAG_W      = 8,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [26:0]      point_x,
    input  logic [26:0]      point_y,
    input  logic [26:0]      point_z,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [26:0]      distance,
    output logic [TAG_W-1:0] out_tag
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [4:0]       v;
    logic [TAG_W-1:0] t [5];
    logic [26:0]      ax, ay, az, da, db, dc, m1, b1, c, q, r4;
    logic [2:0]       inflight;
    logic [AW:0]      count;
    logic [AW-1:0]    wp, rp;
    logic [26:0]      mem_d [FIFO_DEPTH];
    logic [TAG_W-1:0] mem_t [FIFO_DEPTH];
    logic             accept, push, pop;

    // Magnitudes only: bit 26 is already clear, so raw compares order them.
    function automatic logic [26:0] umax(input logic [26:0] a, input logic [26:0] b);
        return a[25:0] > b[25:0] ? a : b;
    endfunction

    function automatic logic [26:0] umin(input logic [26:0] a, input logic [26:0] b);
        return a[25:0] < b[25:0] ? a : b;
    endfunction

    function automatic logic [26:0] fmax(input logic [26:0] a, input logic [26:0] b);
        logic a_gt;
        a_gt = (a[26] != b[26]) ? ~a[26] : (a[26] ? a[25:0] < b[25:0] : a[25:0] > b[25:0]);
        return a_gt ? a : b;
    endfunction

    assign accept    = in_valid & in_ready;
    assign inflight  = 3'($countones(v));
    assign in_ready  = 32'(count) + 32'(inflight) < 32'(FIFO_DEPTH);
    assign push      = v[4];
    assign pop       = out_valid & out_ready;
    assign out_valid = count != '0;
    assign distance  = mem_d[rp];
    assign out_tag   = mem_t[rp];
    assign da        = umax(ax, ay);
    assign db        = umax(ay, az);
    assign dc        = umax(az, ax);

    sdf_fp_add u_arm (.clk(clk), .a(m1), .b({~ARM[26], ARM[25:0]}), .y(c));
    sdf_fp_add u_box (.clk(clk), .a(b1), .b({~BOUND[26], BOUND[25:0]}), .y(q));

    always_ff @(posedge clk) begin
        ax   <= point_x & 27'h3ffffff;
        ay   <= point_y & 27'h3ffffff;
        az   <= point_z & 27'h3ffffff;
        t[0] <= in_tag;
        for (int i = 1; i < 5; i++)
            t[i] <= t[i-1];
        m1   <= umin(umin(da, db), dc);
        b1   <= umax(da, az);
        r4   <= BOUND_EN ? fmax(c, q) : c;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v     <= '0;
            count <= '0;
            wp    <= '0;
            rp    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_d[i] <= '0;
                mem_t[i] <= '0;
            end
        end else begin
            v <= {v[3:0], accept};
            if (push) begin
                mem_d[wp] <= r4;
                mem_t[wp] <= t[4];
                wp        <= wp + 1'b1;
            end
            if (pop)
                rp <= rp + 1'b1;
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end
endmodule

// File: doc/sdf_cross_pipe.md
Name: sdf_cross_pipe

Overview:
- Parametrised, fully pipelined signed-distance unit for the axis-aligned cross primitive in the 27-bit float format (sign 26, exponent 25:18 bias 127, mantissa 17:0).
- Generalises the fixed infinite cross in three ways: configurable arm half-width, an optional box-bounded mode, and a sideband tag.
- Adds a valid/ready handshake with credit-based output buffering, so the raymarch core can apply backpressure without stalling the non-stallable FpAdd pipeline.
- Sits between the ray-step point generator and the march controller's min-distance reducer.

Parameters:
- ARM, 27'h1fc0000 (1.0), arm half-width subtracted from the cross distance.
- BOUND_EN, 0, 0 = infinite cross; 1 = cross intersected with a cube.
- BOUND, 27'h2040000 (4.0), cube half-extent; used only when BOUND_EN = 1.
- TAG_W, 8, sideband tag width.
- FIFO_DEPTH, 8, output buffer entries; power of two, minimum 8.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  input point valid
- in_ready  out  1  unit can accept a point this cycle
- point_x  in  27  x coordinate, FP27
- point_y  in  27  y coordinate, FP27
- point_z  in  27  z coordinate, FP27
- in_tag  in  TAG_W  sideband, returned unchanged with the result
- out_valid  out  1  result available at the FIFO head
- out_ready  in  1  consumer accepts the head this cycle
- distance  out  27  FP27 signed distance
- out_tag  out  TAG_W  tag of the head result

Behaviour:
- Accept condition: in_valid && in_ready.
- Pipeline: never stalls. Fixed LATENCY = 5 cycles from the accept edge to the FIFO write.
  - S0: register |x|, |y|, |z| (clear bit 26), plus the valid bit and tag.
  - S1: da = max(|x|,|y|), db = max(|y|,|z|), dc = max(|z|,|x|), m = min(da, db, dc), b = max(|x|,|y|,|z|); register all. FpCompare is combinational. Ties may select either operand; the values are equal.
  - S2–S3: two parallel FpAdd instances (2-cycle latency): c = m + (−ARM), q = b + (−BOUND). Negation flips bit 26 of the parameter.
  - S4: result = BOUND_EN ? max(c, q) : c; register the result and push it into the FIFO.
  - The valid bit and tag travel alongside the data in a LATENCY-deep shift register.
- Credits:
  - inflight = number of valid bits set in stages S0–S4.
  - in_ready = (fifo_count + inflight) < FIFO_DEPTH. This is registered-free but contains no combinational path from in_valid.
  - Guarantees the FIFO never overflows.
- FIFO:
  - First-word-fall-through; out_valid = (fifo_count != 0); distance/out_tag show the head.
  - Pop on out_valid && out_ready.
  - Simultaneous push and pop in the same cycle leaves the count unchanged; both occur.
  - Read/write pointers wrap modulo FIFO_DEPTH.
  - A push into an empty FIFO is visible on out_valid the next cycle.
- Ordering: results leave strictly in acceptance order; tags are never reordered.
- Reset (async assert, released synchronously to clk):
  - All valid bits, pointers and counts go to 0.
  - out_valid = 0, in_ready = 1 from the first cycle after reset deasserts.
  - distance and out_tag reset to 0.
  - In-flight and buffered results are discarded without output.
- Unsupported inputs: no NaN/Inf handling. Denormals follow FpAdd behaviour. −0 is treated as +0 after abs.
- Throughput: one point per cycle sustained while out_ready = 1.

Test Plan:
- Origin, infinite mode: BOUND_EN=0, ARM=1.0, point (0,0,0), tag 0x11 → distance 27'h5fc0000 (−1.0), out_tag 0x11, exactly 6 cycles after the accept edge with out_ready=1.
- Generic point, infinite mode: (2.0, 3.0, 0.5) = (27'h2000000, 27'h2020000, 27'h1f80000) → m = 2.0, distance 27'h1fc0000 (1.0).
- Bounded mode: BOUND_EN=1, BOUND=4.0, point (6.0, 0, 0) = 27'h2060000 → c = −1.0, q = 2.0, distance 27'h2000000 (2.0). The same point with BOUND_EN=0 → 27'h5fc0000.
- Backpressure: FIFO_DEPTH=8, out_ready=0, in_valid held high with tags 0..9 → exactly 8 accepted, then in_ready=0. Raise out_ready → tags 0..7 emerge on consecutive cycles, then tags 8 and 9 are accepted and emerge in order, with no loss or duplication.
- Streaming: 100 random points back-to-back, out_ready=1 → in_ready stays 1 throughout, one result per cycle, each bit-exact against a reference model with matching tags.
- Reset mid-operation: with 3 points in the pipe and 4 in the FIFO, pulse reset for 1 cycle asynchronously → out_valid=0 and in_ready=1 immediately after release; no stale result ever appears; the next point returns correctly after 6 cycles.
